// File: rtl/sram_confreg_pkg.sv
// Shared constants for the SRAM-port configuration register block:
// register offsets, reset values, register select codes and a byte-merge helper.
package confreg_pkg;

   localparam logic [15:0] OFF_CR0       = 16'h8000;
   localparam logic [15:0] OFF_TIMER     = 16'hE000;
   localparam logic [15:0] OFF_TIMER_CMP = 16'hE004;
   localparam logic [15:0] OFF_LED       = 16'hF000;
   localparam logic [15:0] OFF_LED_RG0   = 16'hF004;
   localparam logic [15:0] OFF_LED_RG1   = 16'hF008;
   localparam logic [15:0] OFF_NUM       = 16'hF010;
   localparam logic [15:0] OFF_SWITCH    = 16'hF020;
   localparam logic [15:0] OFF_SIMU_FLAG = 16'hFFEC;

   localparam int NUM_CR = 8;

   localparam logic [31:0] CR_RST        = 32'h0000_0000;
   localparam logic [31:0] TIMER_RST     = 32'h0000_0000;
   localparam logic [31:0] CMP_RST       = 32'h0000_0000;
   localparam logic [31:0] NUM_RST       = 32'h0000_0000;
   localparam logic [1:0]  LED_RG_RST    = 2'b00;
   localparam logic [31:0] SIMU_FLAG_VAL = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_CR,
      SEL_TIMER,
      SEL_TIMER_CMP,
      SEL_LED,
      SEL_LED_RG0,
      SEL_LED_RG1,
      SEL_NUM,
      SEL_SWITCH,
      SEL_SIMU_FLAG
   } reg_sel_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

   // CR0..CR7 occupy one aligned 32-byte window, so only the upper bits select it.
   function automatic reg_sel_e decode_off(input logic [15:0] off);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (off[15:5] == OFF_CR0[15:5]) begin
         sel = SEL_CR;
      end else begin
         case (off)
            OFF_TIMER:     sel = SEL_TIMER;
            OFF_TIMER_CMP: sel = SEL_TIMER_CMP;
            OFF_LED:       sel = SEL_LED;
            OFF_LED_RG0:   sel = SEL_LED_RG0;
            OFF_LED_RG1:   sel = SEL_LED_RG1;
            OFF_NUM:       sel = SEL_NUM;
            OFF_SWITCH:    sel = SEL_SWITCH;
            OFF_SIMU_FLAG: sel = SEL_SIMU_FLAG;
            default:       sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/sram_confreg_if.sv
// CPU data-side SRAM-like port: request (en/wen/addr/wdata) and one-cycle-late rdata.
interface sram_confreg_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/sram_confreg_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match interrupt;
// a compare-register write clears the interrupt and beats a same-cycle match.
module confreg_timer
   import confreg_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        timer_we,
   input  logic        cmp_we,
   input  logic [3:0]  wen,
   input  logic [31:0] wdata,
   output logic [31:0] timer_val,
   output logic [31:0] cmp_val,
   output logic        timer_int
);

   logic [31:0] timer_reg, timer_next;
   logic [31:0] cmp_reg,   cmp_next;
   logic        int_reg,   int_next;

   always_comb begin
      timer_next = timer_reg + 32'd1;
      if (timer_we) timer_next = merge_bytes(timer_reg, wdata, wen);

      cmp_next = cmp_reg;
      if (cmp_we) cmp_next = merge_bytes(cmp_reg, wdata, wen);

      int_next = int_reg;
      if ((cmp_reg != 32'd0) && (timer_reg == cmp_reg)) int_next = 1'b1;
      if (cmp_we) int_next = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_reg <= TIMER_RST;
         cmp_reg   <= CMP_RST;
         int_reg   <= 1'b0;
      end else begin
         timer_reg <= timer_next;
         cmp_reg   <= cmp_next;
         int_reg   <= int_next;
      end
   end

   assign timer_val = timer_reg;
   assign cmp_val   = cmp_reg;
   assign timer_int = int_reg;

endmodule

// File: rtl/sram_confreg.sv
// Memory-mapped config/peripheral register block answering the CPU data SRAM port:
// scratch regs, LED/number outputs, synchronized switches and a compare timer.
module sram_confreg
   import confreg_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'hBFAF_0000,
   parameter int          LED_W = 16,
   parameter int          SW_W  = 8
) (
   input  logic             clk,
   input  logic             resetn,
   sram_confreg_if.slave    bus,
   input  logic [SW_W-1:0]  switch_i,
   output logic [LED_W-1:0] led_o,
   output logic [1:0]       led_rg0_o,
   output logic [1:0]       led_rg1_o,
   output logic [31:0]      num_o,
   output logic             timer_int_o
);

   logic        hit, wr, rd;
   logic [15:0] off;
   reg_sel_e    sel;
   logic [2:0]  cr_idx;
   logic [3:0]  wen;
   logic [31:0] wdata;

   logic [31:0]      cr_reg [NUM_CR];
   logic [LED_W-1:0] led_reg;
   logic [1:0]       rg0_reg, rg1_reg;
   logic [31:0]      num_reg;
   logic [SW_W-1:0]  sw_meta_reg, sw_sync_reg;
   logic [31:0]      rdata_reg, rdata_next;
   logic [31:0]      rd_val;
   logic [31:0]      led_wr_val, rg0_wr_val, rg1_wr_val;
   logic [31:0]      timer_val, cmp_val;
   logic             timer_int;
   logic             unused_ok;

   assign wen    = bus.data_sram_wen;
   assign wdata  = bus.data_sram_wdata;
   assign off    = {bus.data_sram_addr[15:2], 2'b00};
   assign hit    = bus.data_sram_en && (bus.data_sram_addr[31:16] == BASE[31:16]);
   assign wr     = hit && (wen != 4'b0000);
   assign rd     = hit && (wen == 4'b0000);
   assign sel    = decode_off(off);
   assign cr_idx = off[4:2];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CR; gi++) begin : g_cr
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               cr_reg[gi] <= CR_RST;
            else if (wr && (sel == SEL_CR) && (cr_idx == 3'(gi)))
               cr_reg[gi] <= merge_bytes(cr_reg[gi], wdata, wen);
         end
      end
   endgenerate

   // Narrow registers merge against a zero-extended copy; upper lanes fall away.
   assign led_wr_val = merge_bytes(32'(led_reg), wdata, wen);
   assign rg0_wr_val = merge_bytes(32'(rg0_reg), wdata, wen);
   assign rg1_wr_val = merge_bytes(32'(rg1_reg), wdata, wen);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_reg <= '1;
         rg0_reg <= LED_RG_RST;
         rg1_reg <= LED_RG_RST;
         num_reg <= NUM_RST;
      end else if (wr) begin
         if (sel == SEL_LED)     led_reg <= led_wr_val[LED_W-1:0];
         if (sel == SEL_LED_RG0) rg0_reg <= rg0_wr_val[1:0];
         if (sel == SEL_LED_RG1) rg1_reg <= rg1_wr_val[1:0];
         if (sel == SEL_NUM)     num_reg <= merge_bytes(num_reg, wdata, wen);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         sw_meta_reg <= switch_i;
         sw_sync_reg <= sw_meta_reg;
      end
   end

   confreg_timer u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .timer_we  (wr && (sel == SEL_TIMER)),
      .cmp_we    (wr && (sel == SEL_TIMER_CMP)),
      .wen       (wen),
      .wdata     (wdata),
      .timer_val (timer_val),
      .cmp_val   (cmp_val),
      .timer_int (timer_int)
   );

   always_comb begin
      rd_val = '0;
      case (sel)
         SEL_CR:        rd_val = cr_reg[cr_idx];
         SEL_TIMER:     rd_val = timer_val;
         SEL_TIMER_CMP: rd_val = cmp_val;
         SEL_LED:       rd_val = 32'(led_reg);
         SEL_LED_RG0:   rd_val = 32'(rg0_reg);
         SEL_LED_RG1:   rd_val = 32'(rg1_reg);
         SEL_NUM:       rd_val = num_reg;
         SEL_SWITCH:    rd_val = 32'(sw_sync_reg);
         SEL_SIMU_FLAG: rd_val = SIMU_FLAG_VAL;
         default:       rd_val = '0;
      endcase
   end

   // Only reads move rdata; a read that misses the region returns zero.
   always_comb begin
      rdata_next = rdata_reg;
      if (bus.data_sram_en && (wen == 4'b0000))
         rdata_next = rd ? rd_val : 32'd0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rdata_reg <= '0;
      else         rdata_reg <= rdata_next;
   end

   assign bus.data_sram_rdata = rdata_reg;
   assign led_o       = led_reg;
   assign led_rg0_o   = rg0_reg;
   assign led_rg1_o   = rg1_reg;
   assign num_o       = num_reg;
   assign timer_int_o = timer_int;

   assign unused_ok = ^{bus.data_sram_addr[1:0], led_wr_val, rg0_wr_val, rg1_wr_val};

endmodule
